// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - shares the system bus between the CPU and one external master
// Define ARB_TIMEOUT_EN to add the idle-grant watchdog and the sticky ext_timeout_o flag.
module cpu_bus_arbiter #(
    parameter int unsigned address_width    = 32,
    parameter int unsigned HaltSettleCycles = 2,
    parameter int unsigned ReadLatency      = 1,
    parameter int unsigned MaxBurst         = 16,
    parameter int unsigned CpuMinCycles     = 4,
    parameter int unsigned TimeoutCycles    = 256
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [address_width-1:0] cpu_address_i,
    input  logic [31:0]              cpu_data_i,
    input  logic                     cpu_we_i,
    input  logic [3:0]               cpu_we_ram_i,
    output logic                     cpu_halt_o,
    input  logic                     ext_req_i,
    input  logic                     ext_valid_i,
    input  logic [address_width-1:0] ext_address_i,
    input  logic [31:0]              ext_wdata_i,
    input  logic [3:0]               ext_we_ram_i,
    output logic                     ext_grant_o,
    output logic                     ext_ack_o,
    output logic [31:0]              ext_rdata_o,
    output logic                     ext_timeout_o,
    input  logic [31:0]              bus_data_i,
    output logic [address_width-1:0] address_o,
    output logic [31:0]              data_o,
    output logic                     we_o,
    output logic [3:0]               we_ram_o
);
    typedef enum logic [2:0] {CPU_OWN, HALT_WAIT, EXT_IDLE, EXT_XFER, RELEASE} state_t;

    localparam logic [15:0] MinLoad    = 16'(CpuMinCycles);
    localparam logic [15:0] SettleLoad = 16'(HaltSettleCycles - 1);
    localparam logic [15:0] LatLoad    = 16'(ReadLatency);
    localparam logic [15:0] BurstLast  = 16'(MaxBurst - 1);

    if (HaltSettleCycles < 1 || ReadLatency < 1 || MaxBurst < 1 || TimeoutCycles < 1) begin : g_param_check
        $error("cpu_bus_arbiter: HaltSettleCycles, ReadLatency, MaxBurst and TimeoutCycles must be >= 1");
    end

    state_t                     state;
    logic [15:0]                min_cnt;
    logic [15:0]                settle_cnt;
    logic [15:0]                lat_cnt;
    logic [15:0]                burst_cnt;
    logic [address_width-1:0]   xfer_addr_q;
    logic [31:0]                xfer_data_q;
    logic [3:0]                 xfer_strb_q;
    logic                       xfer_we_q;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] WdLast = 16'(TimeoutCycles - 1);
    logic [15:0] wd_cnt;
`else
    assign ext_timeout_o = 1'b0;
`endif

    // The CPU keeps the bus until the grant; RELEASE hands it back with halt already low.
    always_comb begin
        address_o = xfer_addr_q;
        data_o    = xfer_data_q;
        we_o      = xfer_we_q;
        we_ram_o  = xfer_strb_q;
        if (state == CPU_OWN || state == HALT_WAIT || state == RELEASE) begin
            address_o = cpu_address_i;
            data_o    = cpu_data_i;
            we_o      = cpu_we_i;
            we_ram_o  = cpu_we_ram_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= CPU_OWN;
            cpu_halt_o  <= 1'b0;
            ext_grant_o <= 1'b0;
            ext_ack_o   <= 1'b0;
            ext_rdata_o <= '0;
            min_cnt     <= '0;
            settle_cnt  <= '0;
            lat_cnt     <= '0;
            burst_cnt   <= '0;
            xfer_addr_q <= '0;
            xfer_data_q <= '0;
            xfer_strb_q <= '0;
            xfer_we_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wd_cnt        <= '0;
            ext_timeout_o <= 1'b0;
`endif
        end else begin
            // Bus strobe registers live for exactly one cycle after being loaded.
            ext_ack_o   <= 1'b0;
            xfer_addr_q <= '0;
            xfer_data_q <= '0;
            xfer_strb_q <= '0;
            xfer_we_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
            case (state)
                CPU_OWN: begin
                    if (min_cnt != 16'd0) begin
                        min_cnt <= min_cnt - 16'd1;
                    end else if (ext_req_i) begin
                        state      <= HALT_WAIT;
                        cpu_halt_o <= 1'b1;
                        settle_cnt <= SettleLoad;
                    end
                end
                HALT_WAIT: begin
                    if (!ext_req_i) begin
                        state      <= RELEASE;
                        cpu_halt_o <= 1'b0;
                    end else if (settle_cnt == 16'd0) begin
                        state       <= EXT_IDLE;
                        ext_grant_o <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 16'd1;
                    end
                end
                EXT_IDLE: begin
                    if (ext_valid_i) begin
                        state       <= EXT_XFER;
                        xfer_addr_q <= ext_address_i;
                        xfer_data_q <= ext_wdata_i;
                        xfer_strb_q <= ext_we_ram_i;
                        xfer_we_q   <= |ext_we_ram_i;
                        lat_cnt     <= LatLoad;
                    end else if (!ext_req_i) begin
                        state       <= RELEASE;
                        ext_grant_o <= 1'b0;
                        cpu_halt_o  <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (wd_cnt == WdLast) begin
                        state         <= RELEASE;
                        ext_grant_o   <= 1'b0;
                        cpu_halt_o    <= 1'b0;
                        ext_timeout_o <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                EXT_XFER: begin
                    if (lat_cnt == 16'd0) begin
                        ext_rdata_o <= bus_data_i;
                        ext_ack_o   <= 1'b1;
                        if (burst_cnt == BurstLast) begin
                            state       <= RELEASE;
                            ext_grant_o <= 1'b0;
                            cpu_halt_o  <= 1'b0;
                            burst_cnt   <= '0;
                        end else begin
                            state     <= EXT_IDLE;
                            burst_cnt <= burst_cnt + 16'd1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 16'd1;
                    end
                end
                RELEASE: begin
                    state     <= CPU_OWN;
                    min_cnt   <= MinLoad;
                    burst_cnt <= '0;
                end
                default: state <= CPU_OWN;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - scoreboard bench for cpu_bus_arbiter
// Honours ARB_TIMEOUT_EN to select the watchdog expectations.
module tb_cpu_bus_arbiter;
    logic        clk_i;
    logic        reset_i;
    logic [31:0] cpu_address_i;
    logic [31:0] cpu_data_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_we_ram_i;
    logic        cpu_halt_o;
    logic        ext_req_i;
    logic        ext_valid_i;
    logic [31:0] ext_address_i;
    logic [31:0] ext_wdata_i;
    logic [3:0]  ext_we_ram_i;
    logic        ext_grant_o;
    logic        ext_ack_o;
    logic [31:0] ext_rdata_o;
    logic        ext_timeout_o;
    logic [31:0] bus_data_i;
    logic [31:0] address_o;
    logic [31:0] data_o;
    logic        we_o;
    logic [3:0]  we_ram_o;

    cpu_bus_arbiter #(.TimeoutCycles(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cpu_address_i(cpu_address_i), .cpu_data_i(cpu_data_i), .cpu_we_i(cpu_we_i),
        .cpu_we_ram_i(cpu_we_ram_i), .cpu_halt_o(cpu_halt_o),
        .ext_req_i(ext_req_i), .ext_valid_i(ext_valid_i), .ext_address_i(ext_address_i),
        .ext_wdata_i(ext_wdata_i), .ext_we_ram_i(ext_we_ram_i), .ext_grant_o(ext_grant_o),
        .ext_ack_o(ext_ack_o), .ext_rdata_o(ext_rdata_o), .ext_timeout_o(ext_timeout_o),
        .bus_data_i(bus_data_i), .address_o(address_o), .data_o(data_o),
        .we_o(we_o), .we_ram_o(we_ram_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        we;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_rdata[$];
    int          vectors = 0;
    int          miscompares = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack pops an expected read value, every granted bus beat pops an expected beat.
    always @(negedge clk_i) begin
        beat_t b;
        logic [31:0] r;
        if (ext_ack_o === 1'b1) begin
            vectors++;
            if (exp_rdata.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_ack actual rdata=%h expected no ack at %0t", ext_rdata_o, $time);
            end else begin
                r = exp_rdata.pop_front();
                if (ext_rdata_o !== r) begin
                    miscompares++;
                    $display("FAIL ack_rdata actual=%h expected=%h at %0t", ext_rdata_o, r, $time);
                end
            end
        end
        if (ext_grant_o === 1'b1 && (address_o != 0 || we_ram_o != 0 || we_o)) begin
            vectors++;
            if (exp_beats.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat actual addr=%h we=%b expected no beat at %0t", address_o, we_o, $time);
            end else begin
                b = exp_beats.pop_front();
                if (address_o !== b.addr || data_o !== b.data || we_ram_o !== b.strb || we_o !== b.we) begin
                    miscompares++;
                    $display("FAIL bus_beat actual addr=%h data=%h strb=%h we=%b expected addr=%h data=%h strb=%h we=%b",
                             address_o, data_o, we_ram_o, we_o, b.addr, b.data, b.strb, b.we);
                end
            end
        end
    end

    // Issued in an EXT_IDLE cycle; returns in the ack cycle (two cycles after the bus strobe).
    task automatic do_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] strb,
                           input logic [31:0] bv, input bit hold_valid, input bit drop_req);
        check("grant_at_issue", 32'(ext_grant_o), 32'd1);
        ext_valid_i   = 1'b1;
        ext_address_i = a;
        ext_wdata_i   = wd;
        ext_we_ram_i  = strb;
        if (drop_req) ext_req_i = 1'b0;
        exp_beats.push_back('{addr: a, data: wd, strb: strb, we: |strb});
        exp_rdata.push_back(bv);
        bus_data_i = ~bv;
        tick();
        if (hold_valid) ext_address_i = 32'h0000_3333;
        else ext_valid_i = 1'b0;
        tick();
        check("ack_not_early", 32'(ext_ack_o), 32'd0);
        bus_data_i = bv;
        tick();
        ext_valid_i = 1'b0;
        bus_data_i  = ~bv;
        check("ack_latency", 32'(ext_ack_o), 32'd1);
    endtask

    initial begin
        int n;
        reset_i = 1'b1;
        cpu_address_i = '0; cpu_data_i = '0; cpu_we_i = 1'b0; cpu_we_ram_i = '0;
        ext_req_i = 1'b0; ext_valid_i = 1'b0; ext_address_i = '0; ext_wdata_i = '0;
        ext_we_ram_i = '0; bus_data_i = '0;
        tick(2);
        check("rst_halt", 32'(cpu_halt_o), 32'd0);
        check("rst_grant", 32'(ext_grant_o), 32'd0);
        check("rst_ack", 32'(ext_ack_o), 32'd0);
        check("rst_rdata", ext_rdata_o, 32'd0);
        check("rst_timeout", 32'(ext_timeout_o), 32'd0);
        reset_i = 1'b0;

        // CPU-only traffic passes straight through
        cpu_address_i = 32'h100; cpu_data_i = 32'hCAFE_0001; cpu_we_i = 1'b1; cpu_we_ram_i = 4'hF;
        #1;
        check("cpu_pass_addr", address_o, 32'h100);
        check("cpu_pass_we", 32'(we_o), 32'd1);
        check("cpu_pass_data", data_o, 32'hCAFE_0001);
        check("cpu_pass_strb", 32'(we_ram_o), 32'hF);
        tick();
        cpu_address_i = '0; cpu_data_i = '0; cpu_we_i = 1'b0; cpu_we_ram_i = '0;
        check("cpu_only_halt", 32'(cpu_halt_o), 32'd0);
        tick(3);

        // Request: halt next cycle, grant after settle
        ext_req_i = 1'b1;
        tick();
        check("halt_after_req", 32'(cpu_halt_o), 32'd1);
        check("no_grant_settle1", 32'(ext_grant_o), 32'd0);
        cpu_address_i = 32'h104;
        #1;
        check("halt_wait_pass", address_o, 32'h104);
        tick();
        check("no_grant_settle2", 32'(ext_grant_o), 32'd0);
        tick();
        check("grant", 32'(ext_grant_o), 32'd1);
        check("granted_bus_idle", address_o, 32'd0);
        cpu_address_i = '0;

        // Write, read, valid held during transfer, then valid with request drop
        do_xfer(32'h2000, 32'hDEAD_BEEF, 4'hF, 32'h0BAD_F00D, 1'b0, 1'b0);
        do_xfer(32'h2004, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0, 1'b0);
        tick(2);
        check("rdata_hold", ext_rdata_o, 32'h1234_5678);
        do_xfer(32'h2008, 32'h5A5A_0001, 4'h3, 32'h7777_0001, 1'b1, 1'b0);
        do_xfer(32'h200C, 32'h5A5A_0002, 4'h0, 32'h7777_0002, 1'b0, 1'b1);
        check("grant_until_ack", 32'(ext_grant_o), 32'd1);
        tick();
        check("drop_release_grant", 32'(ext_grant_o), 32'd0);
        check("drop_release_halt", 32'(cpu_halt_o), 32'd0);

        // Strobe while not granted is ignored
        tick();
        ext_valid_i = 1'b1; ext_address_i = 32'h5555; ext_we_ram_i = 4'hF;
        #1;
        check("ungranted_pass", address_o, 32'd0);
        tick();
        ext_valid_i = 1'b0; ext_address_i = '0; ext_we_ram_i = '0;
        tick(6);

        // Sixteen back-to-back transfers force a release
        ext_req_i = 1'b1;
        tick(3);
        check("burst_grant", 32'(ext_grant_o), 32'd1);
        for (int i = 0; i < 16; i++)
            do_xfer(32'h3000 + 32'(i * 4), 32'h1000_0000 + 32'(i), (i % 2 == 0) ? 4'hF : 4'h0,
                    32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        check("maxburst_release_grant", 32'(ext_grant_o), 32'd0);
        check("maxburst_release_halt", 32'(cpu_halt_o), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("regrant_hold", 32'(ext_grant_o), 32'd0);
            if (k <= 5) check("halt_min_tenure", 32'(cpu_halt_o), 32'd0);
        end
        n = 0;
        while (ext_grant_o !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        check("regrant", 32'(ext_grant_o), 32'd1);

        // Reset during the strobe cycle abandons the transfer
        ext_valid_i = 1'b1; ext_address_i = 32'h4000; ext_wdata_i = 32'h4444_0000; ext_we_ram_i = 4'hF;
        exp_beats.push_back('{addr: 32'h4000, data: 32'h4444_0000, strb: 4'hF, we: 1'b1});
        tick();
        reset_i = 1'b1; ext_valid_i = 1'b0; ext_req_i = 1'b0; cpu_address_i = 32'h108;
        tick();
        check("rst_xfer_halt", 32'(cpu_halt_o), 32'd0);
        check("rst_xfer_grant", 32'(ext_grant_o), 32'd0);
        check("rst_xfer_ack", 32'(ext_ack_o), 32'd0);
        check("rst_xfer_rdata", ext_rdata_o, 32'd0);
        check("rst_xfer_pass", address_o, 32'h108);
        reset_i = 1'b0;
        tick(4);
        cpu_address_i = '0;

        // Idle grant: watchdog behaviour depends on the build
        ext_req_i = 1'b1;
        tick(3);
        check("wd_grant", 32'(ext_grant_o), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("wd_idle_grant", 32'(ext_grant_o), 32'd1);
        end
        tick();
`ifdef ARB_TIMEOUT_EN
        check("wd_release", 32'(ext_grant_o), 32'd0);
        check("wd_flag", 32'(ext_timeout_o), 32'd1);
        ext_req_i = 1'b0;
        tick(4);
        check("wd_sticky", 32'(ext_timeout_o), 32'd1);
`else
        check("no_wd_grant", 32'(ext_grant_o), 32'd1);
        check("no_wd_flag", 32'(ext_timeout_o), 32'd0);
        tick(12);
        check("no_wd_grant_late", 32'(ext_grant_o), 32'd1);
        ext_req_i = 1'b0;
        tick(4);
        check("no_wd_flag_late", 32'(ext_timeout_o), 32'd0);
`endif

        tick(3);
        check("beats_left", 32'(exp_beats.size()), 32'd0);
        check("acks_left", 32'(exp_rdata.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Shares the single system bus between the rv32 CPU wrapper (default owner) and one external master, such as a debug/UART bridge or DMA.
- Takes bus ownership from the CPU by asserting the CPU halt input (`cpu_halt_o` here), waiting out the in-flight access, then granting the external master a bounded tenure of single-beat transfers.
- Sits between the CPU wrapper and the address decoder / bus fabric.

Parameters:
- address_width, 32, bus address width.
- HaltSettleCycles, 2, cycles after halt assertion before external grant; covers the CPU access in flight.
- ReadLatency, 1, cycles from external strobe on bus to `bus_data_i` valid; minimum 1.
- MaxBurst, 16, external transfers per tenure before forced release; minimum 1.
- CpuMinCycles, 4, minimum CPU_OWN cycles after any release before a new request is honoured.
- TimeoutCycles, 256, idle-grant watchdog limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- cpu_address_i  in  address_width  CPU address strobe (nonzero only on new access).
- cpu_data_i  in  32  CPU write data.
- cpu_we_i  in  1  CPU write pulse.
- cpu_we_ram_i  in  4  CPU byte strobes.
- cpu_halt_o  out  1  stalls CPU `mem_ready`.
- ext_req_i  in  1  external master requests tenure; held high for the whole tenure.
- ext_valid_i  in  1  one-cycle transfer strobe.
- ext_address_i  in  address_width  external address.
- ext_wdata_i  in  32  external write data.
- ext_we_ram_i  in  4  byte strobes; nonzero = write, zero = read.
- ext_grant_o  out  1  external master owns bus.
- ext_ack_o  out  1  one-cycle transfer completion.
- ext_rdata_o  out  32  captured read data.
- ext_timeout_o  out  1  sticky watchdog flag.
- bus_data_i  in  32  bus read data.
- address_o  out  address_width  bus address.
- data_o  out  32  bus write data.
- we_o  out  1  bus write pulse.
- we_ram_o  out  4  bus byte strobes.

Behaviour:
- Reset values (all registered outputs): state CPU_OWN, cpu_halt_o=0, ext_grant_o=0, ext_ack_o=0, ext_rdata_o=0, ext_timeout_o=0. All counters cleared.
- Reset mid-tenure: abandons any transfer; no ack is issued.

States:
- CPU_OWN:
  - address_o/data_o/we_o/we_ram_o = cpu_* combinationally (zero-latency passthrough).
  - Entry loads min-tenure counter = CpuMinCycles.
  - If ext_req_i=1 and counter==0 -> HALT_WAIT; cpu_halt_o=1 from the next cycle.
- HALT_WAIT:
  - CPU passthrough continues, so the in-flight access completes.
  - Counts HaltSettleCycles, then -> EXT_IDLE.
  - If ext_req_i drops here -> RELEASE.
- EXT_IDLE:
  - ext_grant_o=1; bus outputs driven to 0.
  - ext_valid_i=1 -> EXT_XFER, latching address/wdata/strobes. Next cycle: address_o=latched address, data_o=latched wdata, we_ram_o=latched strobes, we_o=|strobes. All for exactly one cycle.
  - ext_req_i=0 -> RELEASE.
  - ext_valid_i and ext_req_i falling in the same cycle: transfer is taken; release happens after its ack.
- EXT_XFER:
  - Bus outputs return to 0 after the strobe cycle.
  - ReadLatency cycles after the strobe cycle, bus_data_i is captured into ext_rdata_o (also for writes) and ext_ack_o pulses for 1 cycle.
  - Burst count increments. If count==MaxBurst -> RELEASE, else -> EXT_IDLE.
  - ext_valid_i during EXT_XFER is ignored; no ack.
- RELEASE:
  - ext_grant_o=0 this cycle, cpu_halt_o=0 this cycle, burst count cleared, -> CPU_OWN.
- Latency figures:
  - Request to grant: 1 + HaltSettleCycles cycles, when min-tenure has expired.
  - Strobe to ack: 1 + ReadLatency cycles.
- Forced release at MaxBurst: an external master still holding ext_req_i is re-granted only after CpuMinCycles (no starvation).
- ext_valid_i while ext_grant_o=0: ignored.
- ext_rdata_o holds its value until the next ack.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Watchdog counts consecutive EXT_IDLE cycles without ext_valid_i.
  - At TimeoutCycles -> RELEASE and ext_timeout_o set; it stays set until reset.
  - Counter clears on ext_valid_i and on leaving EXT_IDLE.
- Undefined: no watchdog logic; ext_timeout_o tied 0; a tenure ends only by request drop or MaxBurst.

Test Plan:
- CPU-only traffic, ext_req_i=0: cpu_address_i=0x100 with write -> address_o=0x100, we_o=1 same cycle; cpu_halt_o stays 0.
- ext_req_i high at cycle 10 (min-tenure expired), defaults: cpu_halt_o=1 at 11, ext_grant_o=1 at 13.
- Granted external write: 0x2000/0xDEADBEEF/strobes 0xF -> one cycle of address_o=0x2000, we_o=1, we_ram_o=0xF. Then a read of 0x2004 with bus_data_i=0x12345678 -> ext_ack_o pulse and ext_rdata_o=0x12345678 two cycles after the strobe.
- 16 back-to-back transfers with ext_req_i held -> release after the 16th ack; halt deasserted; grant reasserted no earlier than 4 cycles in CPU_OWN plus the settle time.
- reset_i pulsed during EXT_XFER -> next cycle: halt=0, grant=0, no ack, bus passthrough from CPU.
- With ARB_TIMEOUT_EN, TimeoutCycles=8: grant then 8 idle cycles -> release, ext_timeout_o=1 and sticky. Without the macro, same stimulus keeps grant and ext_timeout_o=0.
